// File: rtl/bias_seq_ctrl.sv
// Purpose: power-up sequencer and trim controller for the IO-ring bandgap/bias cell.
// Latency: all outputs registered; the cell valid flag is qualified through a 2-flop synchronizer (3 edges to READY_O).
// Backpressure: none; TRIM_LOAD_I outside OFF/READY (or lost to a valid drop) is dropped without ack and must be re-issued.
//
// Ports:
//   CLK_I, RST_I             clock, synchronous active-high reset
//   ENABLE_I, VBIAS_REQ_I    level requests: power the cell / drive VBIAS
//   TRIM_*_CFG_I, TRIM_LOAD_I  trim values from config, single-cycle trim update request
//   BG_VALID_N_I             asynchronous active-low valid flag from the cell
//   EN_O, BG_STARTUP_O, EN_VBIAS_O, TRIM_*_O   cell control pins
//   READY_O, FAULT_O, TRIM_ACK_O, STATE_O, RETRY_CNT_O  status back to the config block
module bias_seq_ctrl #(
  parameter int STARTUP_CYC = 16,
  parameter int SETTLE_CYC  = 256,
  parameter int TIMEOUT_CYC = 1024,
  parameter int MAX_RETRY   = 3,
  parameter int CNT_W       = 12
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       ENABLE_I,
  input  logic       VBIAS_REQ_I,
  input  logic [3:0] TRIM_BIAS_CFG_I,
  input  logic [4:0] TRIM_CURV_CFG_I,
  input  logic [4:0] TRIM_VBG_CFG_I,
  input  logic       TRIM_LOAD_I,
  input  logic       BG_VALID_N_I,
  output logic       EN_O,
  output logic       BG_STARTUP_O,
  output logic       EN_VBIAS_O,
  output logic [3:0] TRIM_BIAS_O,
  output logic [4:0] TRIM_CURV_O,
  output logic [4:0] TRIM_VBG_O,
  output logic       READY_O,
  output logic       FAULT_O,
  output logic       TRIM_ACK_O,
  output logic [2:0] STATE_O,
  output logic [1:0] RETRY_CNT_O
);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_STARTUP = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CHECK   = 3'd3,
    ST_READY   = 3'd4,
    ST_FAULT   = 3'd6
  } stateT;

  // Terminal counts: a phase of N cycles ends on the cycle the counter reads N-1.
  localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  // Valid is only trusted in CHECK once both synchronizer stages hold samples
  // taken after CHECK was entered; the flag can glitch while trims change.
  // TIMEOUT_CYC should therefore be at least 3.
  localparam logic [CNT_W-1:0] QUAL_CNT     = CNT_W'(2);
  localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRY);

  stateT            stateQ;
  stateT            stateD;
  logic [CNT_W-1:0] cntQ;
  logic [1:0]       retryQ;
  logic [1:0]       retryD;
  logic             vnMeta;
  logic             vnS;

  logic [3:0]       trimBiasQ;
  logic [4:0]       trimCurvQ;
  logic [4:0]       trimVbgQ;

  logic             enQ;
  logic             startupQ;
  logic             enVbiasQ;
  logic             readyQ;
  logic             faultQ;
  logic             ackQ;

  logic             latchTrim;
  logic             clearTrim;
  logic             ackD;
  logic             failAttempt;
  logic             enD;
  logic             startupD;
  logic             enVbiasD;
  logic             readyD;
  logic             faultD;

  // Next-state logic. ENABLE_I low overrides everything else.
  always_comb begin
    stateD      = stateQ;
    retryD      = retryQ;
    latchTrim   = 1'b0;
    clearTrim   = 1'b0;
    ackD        = 1'b0;
    failAttempt = 1'b0;

    if (!ENABLE_I) begin
      stateD = ST_OFF;
      retryD = 2'd0;
      if (stateQ == ST_OFF) begin
        if (TRIM_LOAD_I) begin
          latchTrim = 1'b1;
          ackD      = 1'b1;
        end
      end else begin
        // Leaving an active session: every output, trims included, returns to 0.
        clearTrim = 1'b1;
      end
    end else begin
      case (stateQ)
        ST_OFF: begin
          latchTrim = 1'b1;
          ackD      = TRIM_LOAD_I;
          retryD    = 2'd0;
          stateD    = ST_STARTUP;
        end
        ST_STARTUP: begin
          if (cntQ == STARTUP_LAST) stateD = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cntQ == SETTLE_LAST) stateD = ST_CHECK;
        end
        ST_CHECK: begin
          if (!vnS && (cntQ >= QUAL_CNT)) begin
            stateD = ST_READY;
          end else if (cntQ == TIMEOUT_LAST) begin
            failAttempt = 1'b1;
          end
        end
        ST_READY: begin
          // Loss of valid takes precedence over a coincident trim request.
          if (vnS) begin
            failAttempt = 1'b1;
          end else if (TRIM_LOAD_I) begin
            latchTrim = 1'b1;
            ackD      = 1'b1;
            stateD    = ST_SETTLE;
          end
        end
        ST_FAULT: begin
          stateD = ST_FAULT;
        end
        default: begin
          stateD = ST_OFF;
        end
      endcase

      if (failAttempt) begin
        if (retryQ < RETRY_LIMIT) begin
          retryD = retryQ + 2'd1;
          stateD = ST_STARTUP;
        end else begin
          stateD = ST_FAULT;
        end
      end
    end
  end

  // Output decode from the next state so pins change on the same edge as the state.
  always_comb begin
    enD      = (stateD == ST_STARTUP) || (stateD == ST_SETTLE) ||
               (stateD == ST_CHECK)   || (stateD == ST_READY);
    startupD = (stateD == ST_STARTUP);
    readyD   = (stateD == ST_READY);
    enVbiasD = readyD && VBIAS_REQ_I;
    faultD   = (stateD == ST_FAULT);
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      vnMeta    <= 1'b1;
      vnS       <= 1'b1;
      stateQ    <= ST_OFF;
      cntQ      <= '0;
      retryQ    <= 2'd0;
      trimBiasQ <= 4'd0;
      trimCurvQ <= 5'd0;
      trimVbgQ  <= 5'd0;
      enQ       <= 1'b0;
      startupQ  <= 1'b0;
      enVbiasQ  <= 1'b0;
      readyQ    <= 1'b0;
      faultQ    <= 1'b0;
      ackQ      <= 1'b0;
    end else begin
      vnMeta <= BG_VALID_N_I;
      vnS    <= vnMeta;
      stateQ <= stateD;
      retryQ <= retryD;

      // Restart timing on every state change; saturate rather than wrap.
      if (!ENABLE_I || (stateD != stateQ)) begin
        cntQ <= '0;
      end else if (cntQ != CNT_MAX) begin
        cntQ <= cntQ + CNT_ONE;
      end

      if (clearTrim) begin
        trimBiasQ <= 4'd0;
        trimCurvQ <= 5'd0;
        trimVbgQ  <= 5'd0;
      end else if (latchTrim) begin
        trimBiasQ <= TRIM_BIAS_CFG_I;
        trimCurvQ <= TRIM_CURV_CFG_I;
        trimVbgQ  <= TRIM_VBG_CFG_I;
      end

      enQ      <= enD;
      startupQ <= startupD;
      enVbiasQ <= enVbiasD;
      readyQ   <= readyD;
      faultQ   <= faultD;
      ackQ     <= ackD;
    end
  end

  assign EN_O         = enQ;
  assign BG_STARTUP_O = startupQ;
  assign EN_VBIAS_O   = enVbiasQ;
  assign READY_O      = readyQ;
  assign FAULT_O      = faultQ;
  assign TRIM_ACK_O   = ackQ;
  assign TRIM_BIAS_O  = trimBiasQ;
  assign TRIM_CURV_O  = trimCurvQ;
  assign TRIM_VBG_O   = trimVbgQ;
  assign STATE_O      = stateQ;
  assign RETRY_CNT_O  = retryQ;

  // VBIAS must never be driven from an unqualified bandgap.
  assert property (@(posedge CLK_I) EN_VBIAS_O |-> READY_O);
  assert property (@(posedge CLK_I) disable iff (RST_I) RETRY_CNT_O <= RETRY_LIMIT);

endmodule

// File: tb/tb_bias_seq_ctrl.sv
// Purpose: self-checking bench for bias_seq_ctrl with randomized trims, delays and VBIAS requests.
// Latency: expectations derived from the phase lengths and the 3-edge valid qualification.
// Backpressure: n/a.
module tb_bias_seq_ctrl;
  localparam int S  = 16;
  localparam int T  = 256;
  localparam int TO = 1024;
  localparam int P  = S + T + TO;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       vbiasReq;
  logic [3:0] cfgBias;
  logic [4:0] cfgCurv;
  logic [4:0] cfgVbg;
  logic       trimLoad;
  logic       validN;
  logic       enO;
  logic       startupO;
  logic       enVbiasO;
  logic [3:0] trimBiasO;
  logic [4:0] trimCurvO;
  logic [4:0] trimVbgO;
  logic       readyO;
  logic       faultO;
  logic       ackO;
  logic [2:0] stateO;
  logic [1:0] retryO;

  // Model of the trims the cell should currently see.
  logic [3:0] latB;
  logic [4:0] latC;
  logic [4:0] latV;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bias_seq_ctrl dut (
    .CLK_I(clk), .RST_I(rst), .ENABLE_I(enable), .VBIAS_REQ_I(vbiasReq),
    .TRIM_BIAS_CFG_I(cfgBias), .TRIM_CURV_CFG_I(cfgCurv), .TRIM_VBG_CFG_I(cfgVbg),
    .TRIM_LOAD_I(trimLoad), .BG_VALID_N_I(validN),
    .EN_O(enO), .BG_STARTUP_O(startupO), .EN_VBIAS_O(enVbiasO),
    .TRIM_BIAS_O(trimBiasO), .TRIM_CURV_O(trimCurvO), .TRIM_VBG_O(trimVbgO),
    .READY_O(readyO), .FAULT_O(faultO), .TRIM_ACK_O(ackO),
    .STATE_O(stateO), .RETRY_CNT_O(retryO)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomCfg();
    cfgBias = 4'($urandom_range(15, 0));
    cfgCurv = 5'($urandom_range(31, 0));
    cfgVbg  = 5'($urandom_range(31, 0));
  endtask

  task automatic chkTrims(input string tag);
    chk({tag, "/trim_bias"}, trimBiasO, latB);
    chk({tag, "/trim_curv"}, trimCurvO, latC);
    chk({tag, "/trim_vbg"}, trimVbgO, latV);
  endtask

  task automatic chkIdle(input string tag);
    chk({tag, "/en"}, enO, 0);
    chk({tag, "/startup"}, startupO, 0);
    chk({tag, "/en_vbias"}, enVbiasO, 0);
    chk({tag, "/ready"}, readyO, 0);
    chk({tag, "/fault"}, faultO, 0);
    chk({tag, "/ack"}, ackO, 0);
    chk({tag, "/state"}, stateO, 0);
    chk({tag, "/retry"}, retryO, 0);
  endtask

  // Drop ENABLE_I; everything must read 0 one edge later.
  task automatic disableChk(input string tag);
    enable = 1'b0;
    tick();
    latB = '0; latC = '0; latV = '0;
    chkIdle(tag);
    chkTrims(tag);
  endtask

  // From OFF: enable, walk the startup/settle phases (with an ignored trim
  // request early in startup), then release valid d cycles into CHECK.
  task automatic powerUp(input int d, input string tag);
    int startCnt = 0;
    int settleCnt = 0;
    int ackCnt = 0;
    int readyCnt = 0;
    randomCfg();
    latB = cfgBias; latC = cfgCurv; latV = cfgVbg;
    validN   = 1'b1;
    vbiasReq = 1'b0;
    enable   = 1'b1;
    for (int i = 1; i <= S + T; i++) begin
      tick();
      if (stateO == 3'd1 && startupO && enO) startCnt++;
      if (stateO == 3'd2 && !startupO && enO) settleCnt++;
      if (ackO) ackCnt++;
      trimLoad = (i == 3);
      if (i == 3) randomCfg();
    end
    tick();
    chk({tag, "/check_state"}, stateO, 3);
    chk({tag, "/startup_cycles"}, startCnt, S);
    chk({tag, "/settle_cycles"}, settleCnt, T);
    chk({tag, "/startup_trim_ack"}, ackCnt, 0);
    chkTrims({tag, "/startup_trim"});
    repeat (d) begin
      tick();
      if (readyO) readyCnt++;
    end
    validN = 1'b0;
    repeat (2) begin
      tick();
      if (readyO) readyCnt++;
    end
    tick();
    chk({tag, "/early_ready"}, readyCnt, 0);
    chk({tag, "/ready"}, readyO, 1);
    chk({tag, "/ready_state"}, stateO, 4);
    chk({tag, "/retry"}, retryO, 0);
    chk({tag, "/en"}, enO, 1);
    chk({tag, "/en_vbias"}, enVbiasO, 0);
  endtask

  task automatic vbiasFollow();
    logic v;
    for (int k = 0; k < 8; k++) begin
      v = 1'($urandom_range(1, 0));
      vbiasReq = v;
      tick();
      chk("vbias_follow", enVbiasO, v);
    end
    vbiasReq = 1'b1;
    tick();
    chk("vbias_on", enVbiasO, 1);
    chk("vbias_ready", readyO, 1);
  endtask

  task automatic retrim();
    int lowCnt = 1;
    int ackCnt = 1;
    int vbOn = 0;
    randomCfg();
    cfgVbg = 5'h13;
    latB = cfgBias; latC = cfgCurv; latV = cfgVbg;
    trimLoad = 1'b1;
    tick();
    trimLoad = 1'b0;
    chk("retrim/ack", ackO, 1);
    chk("retrim/ready_drop", readyO, 0);
    chk("retrim/vbias_drop", enVbiasO, 0);
    chk("retrim/state", stateO, 2);
    chkTrims("retrim");
    for (int i = 0; i < 400 && !readyO; i++) begin
      tick();
      if (!readyO) begin
        lowCnt++;
        if (enVbiasO) vbOn++;
      end
      if (ackO) ackCnt++;
    end
    chk("retrim/low_cycles", lowCnt, T + 3);
    chk("retrim/ack_cycles", ackCnt, 1);
    chk("retrim/vbias_low", vbOn, 0);
    chk("retrim/ready_back", readyO, 1);
    chk("retrim/vbias_back", enVbiasO, 1);
  endtask

  initial begin
    int faultEdge;
    int pulses;
    int hiCnt;
    int n;
    logic prevSt;

    rst = 1'b1; enable = 1'b0; vbiasReq = 1'b0; trimLoad = 1'b0; validN = 1'b1;
    cfgBias = '0; cfgCurv = '0; cfgVbg = '0;
    latB = '0; latC = '0; latV = '0;
    repeat (3) tick();
    chkIdle("reset");
    chkTrims("reset");
    rst = 1'b0;
    tick();

    // Trim loads while OFF.
    for (int k = 0; k < 3; k++) begin
      randomCfg();
      latB = cfgBias; latC = cfgCurv; latV = cfgVbg;
      trimLoad = 1'b1;
      tick();
      trimLoad = 1'b0;
      chk("off_load/ack", ackO, 1);
      chk("off_load/state", stateO, 0);
      chk("off_load/en", enO, 0);
      chkTrims("off_load");
      tick();
      chk("off_load/ack_clr", ackO, 0);
    end

    // Nominal power-up, VBIAS following, re-trim, disable.
    for (int it = 0; it < 2; it++) begin
      powerUp((it == 0) ? 10 : int'($urandom_range(0, 30)), "powerup");
      vbiasFollow();
      retrim();
      disableChk("disable");
    end

    // Loss of valid in READY, then loss coincident with a trim request.
    powerUp(int'($urandom_range(0, 20)), "pu_loss");
    vbiasReq = 1'b1;
    tick();
    chk("loss/vbias_pre", enVbiasO, 1);
    validN = 1'b1;
    tick();
    validN = 1'b0;
    tick();
    chk("loss/vbias_hold", enVbiasO, 1);
    tick();
    chk("loss/vbias_drop", enVbiasO, 0);
    chk("loss/ready_drop", readyO, 0);
    chk("loss/state", stateO, 1);
    chk("loss/retry", retryO, 1);
    n = 0;
    while (!readyO && n < S + T + 50) begin
      tick();
      n++;
    end
    chk("loss/recover_cycles", n, S + T + 3);
    randomCfg();
    validN = 1'b1;
    tick();
    validN = 1'b0;
    tick();
    trimLoad = 1'b1;
    tick();
    trimLoad = 1'b0;
    chk("loss_trim/state", stateO, 1);
    chk("loss_trim/ack", ackO, 0);
    chk("loss_trim/retry", retryO, 2);
    chkTrims("loss_trim");
    disableChk("loss_disable");

    // Reset in the middle of CHECK with ENABLE_I still high.
    randomCfg();
    latB = cfgBias; latC = cfgCurv; latV = cfgVbg;
    validN = 1'b1;
    enable = 1'b1;
    repeat (S + T + 6) tick();
    chk("rst_mid/state_check", stateO, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chkIdle("rst_mid");
    latB = '0; latC = '0; latV = '0;
    chkTrims("rst_mid");
    latB = cfgBias; latC = cfgCurv; latV = cfgVbg;
    tick();
    chk("rst_mid/restart_state", stateO, 1);
    chk("rst_mid/restart_startup", startupO, 1);
    chkTrims("rst_mid/restart");
    repeat (S) tick();
    chk("rst_mid/settle_state", stateO, 2);
    disableChk("rst_disable");

    // Valid never arrives: three restarts then FAULT.
    randomCfg();
    validN = 1'b1;
    enable = 1'b1;
    faultEdge = -1; pulses = 0; hiCnt = 0; prevSt = 1'b0;
    for (int e = 1; e <= 4 * P + 20 && faultEdge < 0; e++) begin
      tick();
      if (startupO) begin
        hiCnt++;
        if (!prevSt) pulses++;
      end
      prevSt = startupO;
      if (faultO) faultEdge = e;
    end
    chk("fault/edge", faultEdge, 1 + 4 * P);
    chk("fault/pulses", pulses, 4);
    chk("fault/startup_cycles", hiCnt, 4 * S);
    chk("fault/en", enO, 0);
    chk("fault/state", stateO, 6);
    chk("fault/retry", retryO, 3);
    trimLoad = 1'b1;
    tick();
    trimLoad = 1'b0;
    chk("fault/trim_ack", ackO, 0);
    tick();
    chk("fault/hold", faultO, 1);
    enable = 1'b0;
    tick();
    chk("fault_clr/state", stateO, 0);
    chk("fault_clr/fault", faultO, 0);
    chk("fault_clr/retry", retryO, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
